// File: rtl/seq_divider.sv
// Restoring shift-subtract unsigned divider. Latency: WIDTH clocks from accept (1 clock if b==0).
// Backpressure: the result is held in DONE while out_ready is low; in_ready stays low until the handshake.
module seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dvd_r;
  logic [WIDTH-1:0] div_r;

  logic [WIDTH:0]   shifted;
  logic             ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] dvd_nxt;

  // One restoring step; the compare is WIDTH+1 bits wide, the low bits of the
  // subtraction are exact because the result is known to be below the divisor.
  always_comb begin
    shifted = {rem_r, dvd_r[WIDTH-1]};
    ge      = (shifted >= {1'b0, div_r});
    rem_nxt = ge ? (shifted[WIDTH-1:0] - div_r) : shifted[WIDTH-1:0];
    dvd_nxt = {dvd_r[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rem_r     <= '0;
      dvd_r     <= '0;
      div_r     <= '0;
      quotient  <= '0;
      remainder <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            in_ready <= 1'b0;
            state    <= CALC;
            cnt      <= '0;
            rem_r    <= '0;
            dvd_r    <= a;
            div_r    <= b;
          end
        end

        CALC: begin
          // A zero divisor spends exactly one CALC cycle, then reports all-ones / dividend.
          if (div_r == '0) begin
            quotient  <= '1;
            remainder <= dvd_r;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            rem_r <= rem_nxt;
            dvd_r <= dvd_nxt;
            cnt   <= cnt + CW'(1);
            if (cnt == CW'(WIDTH - 1)) begin
              quotient  <= dvd_nxt;
              remainder <= rem_nxt;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
